jtframe_pocket_upload: RTL and testbench
========================================

// Module: jtframe_pocket_upload
// PURPOSE
//  Reverse direction of the Pocket bridge download path: serves bridge read requests
//  (e.g. NVRAM save, index 8'hFF) by fetching 4 bytes from the core's ioctl_din port and
//  packing them into one 32-bit word for bridge_rd_data. Sits in clk_rom after the
//  clk_74a->clk_rom strobe/data synchronisers in the Pocket base. Prefetches the next
//  word so that sequential bridge reads are answered in 1 cycle.
// PARAMETERS
//  RD_LAT   2   clk_rom cycles from ioctl_addr change to valid ioctl_din (1..7)
//  AW       25  ioctl address width
// PORTS
//  rst           in   1   reset, asynchronous, active-high
//  clk_rom       in   1   clock
//  upload_en     in   1   high while the active data slot is the upload slot
//  endian_little in   1   0: byte at addr+0 -> word[31:24]; 1: byte at addr+0 -> word[7:0]
//  ds_done       in   1   data-slot-all-complete, synchronised to clk_rom
//  rd_req        in   1   one-cycle read strobe, already in clk_rom
//  rd_addr       in   32  bridge byte address; [1:0] ignored, [AW-1:2] used
//  rd_data       out  32  packed word; held until the next rd_valid
//  rd_valid      out  1   one-cycle strobe: rd_data holds the word for the last accepted rd_req
//  busy          out  1   demand fetch in progress (a new rd_req would be dropped)
//  overrun       out  1   sticky: rd_req was dropped; cleared by rst or upload_en falling
//  ioctl_addr    out  AW  byte address presented to the core
//  ioctl_din     in   8   byte read back from the core
//  ioctl_rd      out  1   high during every cycle a byte is being captured
//  uploading     out  1   high from first accepted rd_req until ds_done or upload_en low
// BEHAVIOUR
//  Reset: rd_data=0, rd_valid=0, busy=0, overrun=0, ioctl_addr=0, ioctl_rd=0,
//   uploading=0, prefetch invalid, FSM=IDLE.
//  Byte fetch: drive ioctl_addr, wait RD_LAT cycles, capture ioctl_din on cycle RD_LAT
//   (ioctl_rd high on that cycle). RD_LAT+1 cycles per byte; 4*(RD_LAT+1) per word.
//  FSM states: IDLE, DEMAND, PREFETCH, HOLD.
//   IDLE: rd_req with prefetch valid and word addr == pf_addr -> rd_data<=pf_word,
//    rd_valid next cycle (latency 1); then PREFETCH at pf_addr+4.
//    rd_req otherwise -> DEMAND at {rd_addr[AW-1:2],2'b00}; busy=1.
//   DEMAND: fetch 4 bytes; on 4th capture rd_data<=word, rd_valid=1 the following cycle,
//    busy=0, go PREFETCH at addr+4. rd_req here -> dropped, overrun<=1.
//   PREFETCH: fetch 4 bytes into pf_word; done -> pf valid, HOLD.
//    rd_req matching pf target -> flag deliver; on completion behave as DEMAND done.
//    rd_req not matching -> abort, pf invalid, restart DEMAND at new address (no overrun).
//   HOLD: same as IDLE with prefetch valid.
//  Address arithmetic: word address modulo 2^AW; pf at {AW{1}}&~3 wraps to 0.
//  Packing: byte k (k=0..3) -> [31-8k -: 8] if endian_little=0, else [8k +: 8].
//   endian_little sampled at the start of each word fetch.
//  upload_en low: FSM->IDLE same cycle, pf invalid, busy=0, uploading=0, overrun=0, no
//   rd_valid. rd_req while upload_en low is ignored (no overrun).
//  ds_done: uploading<=0; in-flight fetch completes normally.
//  rd_req same cycle as upload_en falling: upload_en wins.
//  rst mid-fetch: all outputs return to reset values immediately.
// STRUCTURE
//  Shared package constants: IDX_NVRAM=8'hFF, FSM state encodings.
//  One sub-module: jtframe_pocket_upload_fetch (byte counter + RD_LAT wait counter +
//   packer; start/addr/endian in, word/done out), used by both DEMAND and PREFETCH.
// TESTING
//  RD_LAT=2, bytes mem[a]=a[7:0]; rd_req addr 0x10, endian 0 -> rd_valid 13 cycles
//   later, rd_data=32'h10111213.
//  Same with endian_little=1 -> rd_data=32'h13121110.
//  Back-to-back sequential reads 0x10,0x14 after prefetch done -> 2nd rd_valid 1 cycle
//   after rd_req, rd_data=32'h14151617.
//  rd_req 0x40 during prefetch of 0x14 -> prefetch aborted, rd_data=32'h40414243,
//   overrun stays 0.
//  rd_req during DEMAND -> request dropped, overrun=1, busy stays 1 until first word.
//  rd_addr=0x01FFFFFC -> word returned, prefetch ioctl_addr wraps to 0; upload_en drop
//   mid-fetch -> no rd_valid, busy=0, uploading=0 next cycle.

Source files
------------

// File: rtl/jtframe_pocket_upload_pkg.sv
// Shared constants, FSM encoding and byte-packing helper for the Pocket bridge
// upload path.
package jtframe_pocket_upload_pkg;

  localparam logic [7:0] IDX_NVRAM = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2,
    ST_HOLD     = 2'd3
  } upl_state_e;

  // Byte 0 lands in the MSB lane for big-endian words, in the LSB lane otherwise.
  function automatic logic [31:0] pack_byte(input logic [31:0] word,
                                            input logic [1:0]  idx,
                                            input logic [7:0]  data,
                                            input logic        little);
    logic [31:0] w;
    w = word;
    if (little) w[{idx, 3'b000} +: 8] = data;
    else        w[{~idx, 3'b000} +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_pocket_upload_fetch.sv
// Four-byte word fetcher: walks ioctl_addr through one word, waits RD_LAT
// cycles per byte and packs the captured bytes.
module jtframe_pocket_upload_fetch #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = 25
) (
  input  logic          rst,
  input  logic          clk_rom,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-3:0] start_addr,
  input  logic          endian_little,
  input  logic [7:0]    ioctl_din,
  output logic [AW-1:0] ioctl_addr,
  output logic          ioctl_rd,
  output logic [31:0]   word_c,
  output logic          done_c
);
  import jtframe_pocket_upload_pkg::*;

  localparam int unsigned WW = AW - 2;
  localparam int unsigned CW = 3;

  logic          active_q, active_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    byte_q, byte_d;
  logic [WW-1:0] base_q, base_d;
  logic          endian_q, endian_d;
  logic [31:0]   word_q, word_d;
  logic          rd_q, rd_d;
  logic          capture_c;

  always_comb begin
    active_d  = active_q;
    wait_d    = wait_q;
    byte_d    = byte_q;
    base_d    = base_q;
    endian_d  = endian_q;
    word_d    = word_q;
    capture_c = active_q && (wait_q == CW'(RD_LAT));
    word_c    = pack_byte(word_q, byte_q, ioctl_din, endian_q);
    done_c    = capture_c && (byte_q == 2'd3);

    if (capture_c) begin
      word_d   = word_c;
      byte_d   = byte_q + 2'd1;
      wait_d   = '0;
      active_d = (byte_q != 2'd3);
    end else if (active_q) begin
      wait_d = wait_q + CW'(1);
    end

    // A new start overrides any fetch in flight (prefetch abort / chaining).
    if (start) begin
      active_d = 1'b1;
      base_d   = start_addr;
      byte_d   = 2'd0;
      wait_d   = '0;
      endian_d = endian_little;
      word_d   = '0;
    end
    if (abort) active_d = 1'b0;

    rd_d = active_d && (wait_d == CW'(RD_LAT));
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      wait_q   <= '0;
      byte_q   <= 2'd0;
      base_q   <= '0;
      endian_q <= 1'b0;
      word_q   <= '0;
      rd_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      wait_q   <= wait_d;
      byte_q   <= byte_d;
      base_q   <= base_d;
      endian_q <= endian_d;
      word_q   <= word_d;
      rd_q     <= rd_d;
    end
  end

  assign ioctl_addr = {base_q, byte_q};
  assign ioctl_rd   = rd_q;

endmodule

// File: rtl/jtframe_pocket_upload.sv
// Serves Pocket bridge read requests from the core's ioctl_din port, keeping
// the next sequential word prefetched so streaming reads answer in one cycle.
module jtframe_pocket_upload #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned AW     = 25
) (
  input  logic          rst,
  input  logic          clk_rom,
  input  logic          upload_en,
  input  logic          endian_little,
  input  logic          ds_done,
  input  logic          rd_req,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          overrun,
  output logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_din,
  output logic          ioctl_rd,
  output logic          uploading
);
  import jtframe_pocket_upload_pkg::*;

  localparam int unsigned WW = AW - 2;

  upl_state_e    state_q, state_d;
  logic          pf_valid_q, pf_valid_d;
  logic [WW-1:0] pf_addr_q, pf_addr_d;
  logic [31:0]   pf_word_q, pf_word_d;
  logic [WW-1:0] tgt_q, tgt_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          uploading_q, uploading_d;

  logic          fetch_start_c, fetch_abort_c, fetch_done_c, deliver_c;
  logic [WW-1:0] fetch_addr_c, req_word_c, next_word_c;
  logic [31:0]   fetch_word_c;
  logic          unused_c;

  assign unused_c    = ^{rd_addr[31:AW], rd_addr[1:0]};
  assign req_word_c  = rd_addr[AW-1:2];
  assign next_word_c = tgt_q + WW'(1);

  jtframe_pocket_upload_fetch #(.RD_LAT(RD_LAT), .AW(AW)) u_fetch (
    .rst           (rst),
    .clk_rom       (clk_rom),
    .start         (fetch_start_c),
    .abort         (fetch_abort_c),
    .start_addr    (fetch_addr_c),
    .endian_little (endian_little),
    .ioctl_din     (ioctl_din),
    .ioctl_addr    (ioctl_addr),
    .ioctl_rd      (ioctl_rd),
    .word_c        (fetch_word_c),
    .done_c        (fetch_done_c)
  );

  always_comb begin
    state_d       = state_q;
    pf_valid_d    = pf_valid_q;
    pf_addr_d     = pf_addr_q;
    pf_word_d     = pf_word_q;
    tgt_d         = tgt_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    busy_d        = busy_q;
    overrun_d     = overrun_q;
    uploading_d   = uploading_q;
    fetch_start_c = 1'b0;
    fetch_abort_c = 1'b0;
    fetch_addr_c  = tgt_q;
    deliver_c     = 1'b0;

    if (!upload_en) begin
      state_d       = ST_IDLE;
      pf_valid_d    = 1'b0;
      busy_d        = 1'b0;
      overrun_d     = 1'b0;
      uploading_d   = 1'b0;
      fetch_abort_c = 1'b1;
    end else begin
      if (rd_req && state_q != ST_DEMAND) uploading_d = 1'b1;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (rd_req) begin
            pf_valid_d    = 1'b0;
            fetch_start_c = 1'b1;
            if (pf_valid_q && req_word_c == pf_addr_q) begin
              rd_data_d    = pf_word_q;
              rd_valid_d   = 1'b1;
              tgt_d        = pf_addr_q + WW'(1);
              fetch_addr_c = pf_addr_q + WW'(1);
              state_d      = ST_PREFETCH;
            end else begin
              tgt_d        = req_word_c;
              fetch_addr_c = req_word_c;
              busy_d       = 1'b1;
              state_d      = ST_DEMAND;
            end
          end
        end
        ST_DEMAND: begin
          if (rd_req) overrun_d = 1'b1;
          deliver_c = fetch_done_c;
        end
        ST_PREFETCH: begin
          if (rd_req && req_word_c != tgt_q) begin
            tgt_d         = req_word_c;
            fetch_addr_c  = req_word_c;
            fetch_start_c = 1'b1;
            busy_d        = 1'b1;
            state_d       = ST_DEMAND;
          end else if (fetch_done_c) begin
            if (rd_req) begin
              deliver_c = 1'b1;
            end else begin
              pf_word_d  = fetch_word_c;
              pf_addr_d  = tgt_q;
              pf_valid_d = 1'b1;
              state_d    = ST_HOLD;
            end
          end else if (rd_req) begin
            // Request hits the word in flight: finish it as a demand fetch.
            busy_d  = 1'b1;
            state_d = ST_DEMAND;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (deliver_c) begin
        rd_data_d     = fetch_word_c;
        rd_valid_d    = 1'b1;
        busy_d        = 1'b0;
        tgt_d         = next_word_c;
        fetch_addr_c  = next_word_c;
        fetch_start_c = 1'b1;
        state_d       = ST_PREFETCH;
      end
      if (ds_done) uploading_d = 1'b0;
    end
  end

  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_word_q   <= '0;
      tgt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      uploading_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_word_q   <= pf_word_d;
      tgt_q       <= tgt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      uploading_q <= uploading_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign uploading = uploading_q;

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// Directed bench for jtframe_pocket_upload: core memory returns the low address
// byte RD_LAT cycles after ioctl_addr changes.
module tb_jtframe_pocket_upload;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = 25;

  logic          rst = 1'b1;
  logic          clk_rom = 1'b0;
  logic          upload_en = 1'b0;
  logic          endian_little = 1'b0;
  logic          ds_done = 1'b0;
  logic          rd_req = 1'b0;
  logic [31:0]   rd_addr = '0;
  logic [31:0]   rd_data;
  logic          rd_valid, busy, overrun, ioctl_rd, uploading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_din;
  logic [AW-1:0] addr_p1 = '0;
  logic [AW-1:0] addr_p2 = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk_rom = ~clk_rom;

  always @(posedge clk_rom) begin
    addr_p1 <= ioctl_addr;
    addr_p2 <= addr_p1;
  end
  assign ioctl_din = addr_p2[7:0];

  jtframe_pocket_upload #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .rst           (rst),
    .clk_rom       (clk_rom),
    .upload_en     (upload_en),
    .endian_little (endian_little),
    .ds_done       (ds_done),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .overrun       (overrun),
    .ioctl_addr    (ioctl_addr),
    .ioctl_din     (ioctl_din),
    .ioctl_rd      (ioctl_rd),
    .uploading     (uploading)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req  = 1'b0;
  endtask

  // n counts cycles since the request cycle; bounded so a dead DUT still ends.
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!rd_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) tick();
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ioctl_addr", 32'(ioctl_addr), 32'd0);
    chk("rst_uploading", 32'(uploading), 32'd0);
    rst = 1'b0;
    upload_en = 1'b1;
    tick();

    // Demand read, big-endian
    req(32'h10);
    chk("dem_busy", 32'(busy), 32'd1);
    chk("dem_ioctl_addr", 32'(ioctl_addr), 32'h10);
    wait_valid(1, n);
    chk("dem_lat", 32'(n), 32'd13);
    chk("dem_data", rd_data, 32'h10111213);
    chk("dem_busy_end", 32'(busy), 32'd0);
    chk("dem_uploading", 32'(uploading), 32'd1);

    // Sequential read served from prefetch
    repeat (14) tick();
    req(32'h14);
    wait_valid(1, n);
    chk("pf_lat", 32'(n), 32'd1);
    chk("pf_data", rd_data, 32'h14151617);
    tick();
    chk("pf_valid_pulse", 32'(rd_valid), 32'd0);

    // Little-endian demand read
    endian_little = 1'b1;
    repeat (14) tick();
    req(32'h10);
    wait_valid(1, n);
    chk("le_lat", 32'(n), 32'd13);
    chk("le_data", rd_data, 32'h13121110);

    // Non-matching request aborts the running prefetch
    endian_little = 1'b0;
    repeat (3) tick();
    req(32'h40);
    wait_valid(1, n);
    chk("abort_lat", 32'(n), 32'd13);
    chk("abort_data", rd_data, 32'h40414243);
    chk("abort_overrun", 32'(overrun), 32'd0);

    // Request during demand is dropped
    repeat (14) tick();
    req(32'h80);
    tick();
    tick();
    req(32'h84);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    wait_valid(4, n);
    chk("ovr_lat", 32'(n), 32'd13);
    chk("ovr_data", rd_data, 32'h80818283);

    // Top-of-space word, prefetch wraps to 0
    repeat (14) tick();
    req(32'h01FFFFFC);
    wait_valid(1, n);
    chk("wrap_data", rd_data, 32'hFCFDFEFF);
    chk("wrap_pf_addr", 32'(ioctl_addr), 32'h0);
    chk("wrap_overrun_sticky", 32'(overrun), 32'd1);

    // upload_en drop mid-prefetch
    repeat (4) tick();
    upload_en = 1'b0;
    tick();
    chk("en_lo_busy", 32'(busy), 32'd0);
    chk("en_lo_uploading", 32'(uploading), 32'd0);
    chk("en_lo_overrun", 32'(overrun), 32'd0);

    // Request while disabled is ignored
    req(32'h20);
    tick();
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_overrun", 32'(overrun), 32'd0);
    chk("dis_uploading", 32'(uploading), 32'd0);

    // upload_en drop mid-demand: no rd_valid, no further byte reads
    upload_en = 1'b1;
    req(32'h20);
    chk("md_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    upload_en = 1'b0;
    tick();
    chk("md_busy_off", 32'(busy), 32'd0);
    chk("md_uploading_off", 32'(uploading), 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid || ioctl_rd) seen++;
      tick();
    end
    chk("md_no_valid", 32'(seen), 32'd0);

    // ds_done ends uploading but the fetch completes
    upload_en = 1'b1;
    req(32'h20);
    chk("ds_uploading", 32'(uploading), 32'd1);
    repeat (3) tick();
    ds_done = 1'b1;
    tick();
    ds_done = 1'b0;
    chk("ds_uploading_off", 32'(uploading), 32'd0);
    wait_valid(5, n);
    chk("ds_lat", 32'(n), 32'd13);
    chk("ds_data", rd_data, 32'h20212223);

    // Asynchronous reset mid-prefetch
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("arst_ioctl_addr", 32'(ioctl_addr), 32'h0);
    chk("arst_rd_data", rd_data, 32'h0);
    chk("arst_ioctl_rd", 32'(ioctl_rd), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
